three_input_or_gate: RTL and testbench
======================================

// Module: three_input_or_gate
// PURPOSE
//  - Bitwise 3-input OR of a, b, c, presented combinationally on y.
//  - Registered copy of the result, a rising-edge pulse and a saturating
//    "OR-true" cycle counter, for use as a small status/monitor primitive.
//  - Combinational y must work with no clock running, so the gate can be
//    exercised stand-alone.
// PARAMETERS
//  WIDTH  1   bit width of a, b, c, y, y_q, y_rise (bitwise OR per lane)
//  CNT_W  16  width of hi_cnt
// PORTS
//  clk     in   1      rising-edge clock
//  rst     in   1      synchronous reset, active-high
//  a       in   WIDTH  operand A
//  b       in   WIDTH  operand B
//  c       in   WIDTH  operand C
//  clr     in   1      synchronous clear of hi_cnt
//  y       out  WIDTH  a | b | c, combinational, zero latency
//  y_q     out  WIDTH  y registered, 1-cycle latency
//  y_any   out  1      registered reduction OR of y (|y), 1-cycle latency
//  y_rise  out  WIDTH  1-cycle pulse per lane when y goes 0->1
//  hi_cnt  out  CNT_W  count of cycles with |y == 1, saturating
// BEHAVIOUR
//  - y = a | b | c per bit. Pure combinational: no clk/rst dependence.
//    Updates in the same delta as any input change.
//  - Truth per lane: y=0 only for a=b=c=0; all 7 other combos give y=1.
//  - Reset (rst=1 at posedge): y_q=0, y_any=0, y_rise=0, hi_cnt=0.
//    Reset has priority over clr and over all updates.
//    Reset asserted mid-count zeroes hi_cnt on that edge.
//  - Each posedge with rst=0:
//      y_q    <= y
//      y_any  <= |y
//      y_rise <= y & ~y_q   (compared against the previous registered value)
//      hi_cnt <= clr ? 0 : (|y && hi_cnt != all-ones) ? hi_cnt+1 : hi_cnt
//  - clr and |y=1 on the same edge: clr wins, hi_cnt=0, no increment.
//  - hi_cnt saturates at 2^CNT_W-1. It holds and never wraps.
//  - First edge after reset with y=1: y_rise=1 because y_q was 0.
//  - y held at 1: y_rise is 1 for exactly one cycle.
//  - No handshake. Inputs are sampled every clock.
// TESTING
//  1. WIDTH=1, rst=0, step {a,b,c} 000..111 every 100 ns ->
//     y = 0,1,1,1,1,1,1,1 immediately after each step.
//  2. rst=1 for 2 edges with a=b=c=1 ->
//     y=1 (combinational), y_q=0, y_any=0, y_rise=0, hi_cnt=0.
//  3. Release rst, hold a=1 for 3 edges ->
//     y_q=1 after edge 1; y_rise=1 on edge 1 only; hi_cnt=3.
//  4. Toggle c 0/1 each cycle, a=b=0 ->
//     y_rise pulses on every second edge; hi_cnt counts only the cycles with y=1.
//  5. CNT_W=3, hold y=1 for 10 edges -> hi_cnt stops at 7.
//     Then clr=1 with y=1 -> hi_cnt=0.
//  6. WIDTH=4: a=4'b0001, b=4'b0100, c=0 -> y=4'b0101, y_any=1 next edge.

Source files
------------

// File: rtl/three_input_or_gate_if.sv
// Signal bundle for the three-input OR monitor: operands and clear in,
// combinational result and registered status out.
interface three_input_or_gate_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic             clr;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_q;
    logic             y_any;
    logic [WIDTH-1:0] y_rise;
    logic [CNT_W-1:0] hi_cnt;

    modport master (
        output a, b, c, clr,
        input  y, y_q, y_any, y_rise, hi_cnt
    );

    modport slave (
        input  a, b, c, clr,
        output y, y_q, y_any, y_rise, hi_cnt
    );
endinterface

// File: rtl/three_input_or_gate.sv
// Bitwise three-input OR with a registered copy, per-lane rising-edge pulse
// and a saturating count of cycles in which any lane is high.
module three_input_or_gate #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input logic                   clk,
    input logic                   rst,
    three_input_or_gate_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] y_comb;
    logic [WIDTH-1:0] y_q_r;
    logic [WIDTH-1:0] y_rise_r;
    logic             y_any_r;
    logic [CNT_W-1:0] hi_cnt_r;

    // Combinational path has no clock or reset dependence so the gate works stand-alone.
    assign y_comb = bus.a | bus.b | bus.c;

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q_r    <= '0;
            y_any_r  <= 1'b0;
            y_rise_r <= '0;
            hi_cnt_r <= '0;
        end else begin
            y_q_r    <= y_comb;
            y_any_r  <= |y_comb;
            y_rise_r <= y_comb & ~y_q_r;
            if (bus.clr) begin
                hi_cnt_r <= '0;
            end else if ((|y_comb) && (hi_cnt_r != CNT_MAX)) begin
                hi_cnt_r <= hi_cnt_r + CNT_ONE;
            end
        end
    end

    assign bus.y      = y_comb;
    assign bus.y_q    = y_q_r;
    assign bus.y_any  = y_any_r;
    assign bus.y_rise = y_rise_r;
    assign bus.hi_cnt = hi_cnt_r;
endmodule

// File: tb/tb_three_input_or_gate.sv
// Directed-vector bench for three_input_or_gate: 1-bit, 3-bit-counter and
// 4-lane instances sharing one clock and reset.
module tb_three_input_or_gate;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    three_input_or_gate_if #(.WIDTH(1), .CNT_W(16)) bus1 ();
    three_input_or_gate_if #(.WIDTH(1), .CNT_W(3))  bus_sat ();
    three_input_or_gate_if #(.WIDTH(4), .CNT_W(16)) bus4 ();

    three_input_or_gate #(.WIDTH(1), .CNT_W(16)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    three_input_or_gate #(.WIDTH(1), .CNT_W(3)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_sat)
    );

    three_input_or_gate #(.WIDTH(4), .CNT_W(16)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_truth_table();
        logic [2:0] v;
        logic       exp_y;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            v = i[2:0];
            bus1.a = v[2];
            bus1.b = v[1];
            bus1.c = v[0];
            exp_y = (v != 3'b000);
            #1;
            checks++;
            if (bus1.y !== exp_y) begin
                failures++;
                $display("FAIL truth_abc%b y got=%b exp=%b", v, bus1.y, exp_y);
            end
            #99;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        bus1.a = 1'b1; bus1.b = 1'b1; bus1.c = 1'b1; bus1.clr = 1'b0;
        bus_sat.a = 1'b1; bus_sat.b = 1'b1; bus_sat.c = 1'b1; bus_sat.clr = 1'b0;
        bus4.a = 4'hF; bus4.b = 4'hF; bus4.c = 4'hF; bus4.clr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (bus1.y !== 1'b1) begin
            failures++; $display("FAIL reset_y got=%b exp=1", bus1.y);
        end
        checks++;
        if (bus1.y_q !== 1'b0) begin
            failures++; $display("FAIL reset_y_q got=%b exp=0", bus1.y_q);
        end
        checks++;
        if (bus1.y_any !== 1'b0) begin
            failures++; $display("FAIL reset_y_any got=%b exp=0", bus1.y_any);
        end
        checks++;
        if (bus1.y_rise !== 1'b0) begin
            failures++; $display("FAIL reset_y_rise got=%b exp=0", bus1.y_rise);
        end
        checks++;
        if (bus1.hi_cnt !== 16'd0) begin
            failures++; $display("FAIL reset_hi_cnt got=%0d exp=0", bus1.hi_cnt);
        end
        checks++;
        if (bus4.y_q !== 4'h0) begin
            failures++; $display("FAIL reset_y_q_w4 got=%h exp=0", bus4.y_q);
        end
    endtask

    task automatic test_hold_high();
        logic [15:0] exp_cnt;
        logic        exp_rise;
        @(negedge clk);
        rst = 1'b0;
        bus1.a = 1'b1; bus1.b = 1'b0; bus1.c = 1'b0;
        bus_sat.a = 1'b0; bus_sat.b = 1'b0; bus_sat.c = 1'b0;
        bus4.a = 4'h0; bus4.b = 4'h0; bus4.c = 4'h0;
        @(posedge clk);
        #1;
        for (int e = 1; e <= 3; e++) begin
            if (e > 1) tick();
            exp_cnt  = 16'(e);
            exp_rise = (e == 1);
            checks++;
            if (bus1.y_q !== 1'b1) begin
                failures++; $display("FAIL hold_y_q_edge%0d got=%b exp=1", e, bus1.y_q);
            end
            checks++;
            if (bus1.y_rise !== exp_rise) begin
                failures++; $display("FAIL hold_y_rise_edge%0d got=%b exp=%b", e, bus1.y_rise, exp_rise);
            end
            checks++;
            if (bus1.hi_cnt !== exp_cnt) begin
                failures++; $display("FAIL hold_hi_cnt_edge%0d got=%0d exp=%0d", e, bus1.hi_cnt, exp_cnt);
            end
        end
    endtask

    // Starts from y_q=1, hi_cnt=3 left by test_hold_high.
    task automatic test_toggle();
        logic [15:0] exp_cnt;
        logic        exp_rise;
        logic        c_val;
        exp_cnt = 16'd3;
        for (int e = 0; e < 6; e++) begin
            c_val = e[0];
            @(negedge clk);
            bus1.a = 1'b0; bus1.b = 1'b0; bus1.c = c_val;
            @(posedge clk);
            #1;
            exp_rise = c_val;
            if (c_val) exp_cnt = exp_cnt + 16'd1;
            checks++;
            if (bus1.y_rise !== exp_rise) begin
                failures++; $display("FAIL toggle_y_rise_%0d got=%b exp=%b", e, bus1.y_rise, exp_rise);
            end
            checks++;
            if (bus1.hi_cnt !== exp_cnt) begin
                failures++; $display("FAIL toggle_hi_cnt_%0d got=%0d exp=%0d", e, bus1.hi_cnt, exp_cnt);
            end
        end
    endtask

    task automatic test_saturate_clear();
        logic [2:0] exp_cnt;
        @(negedge clk);
        bus_sat.a = 1'b0; bus_sat.b = 1'b0; bus_sat.c = 1'b0; bus_sat.clr = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus_sat.hi_cnt !== 3'd0) begin
            failures++; $display("FAIL sat_idle_hi_cnt got=%0d exp=0", bus_sat.hi_cnt);
        end
        @(negedge clk);
        bus_sat.b = 1'b1;
        @(posedge clk);
        #1;
        for (int e = 1; e <= 10; e++) begin
            if (e > 1) tick();
            exp_cnt = (e >= 7) ? 3'd7 : 3'(e);
            checks++;
            if (bus_sat.hi_cnt !== exp_cnt) begin
                failures++; $display("FAIL sat_hi_cnt_edge%0d got=%0d exp=%0d", e, bus_sat.hi_cnt, exp_cnt);
            end
        end
        @(negedge clk);
        bus_sat.clr = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus_sat.hi_cnt !== 3'd0) begin
            failures++; $display("FAIL clr_wins_hi_cnt got=%0d exp=0", bus_sat.hi_cnt);
        end
        @(negedge clk);
        bus_sat.clr = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus_sat.hi_cnt !== 3'd1) begin
            failures++; $display("FAIL after_clr_hi_cnt got=%0d exp=1", bus_sat.hi_cnt);
        end
    endtask

    task automatic test_wide();
        tick();
        @(negedge clk);
        bus4.a = 4'b0001; bus4.b = 4'b0100; bus4.c = 4'b0000; bus4.clr = 1'b0;
        #1;
        checks++;
        if (bus4.y !== 4'b0101) begin
            failures++; $display("FAIL wide_y got=%b exp=0101", bus4.y);
        end
        checks++;
        if (bus4.y_any !== 1'b0) begin
            failures++; $display("FAIL wide_y_any_pre got=%b exp=0", bus4.y_any);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus4.y_any !== 1'b1) begin
            failures++; $display("FAIL wide_y_any got=%b exp=1", bus4.y_any);
        end
        checks++;
        if (bus4.y_q !== 4'b0101) begin
            failures++; $display("FAIL wide_y_q got=%b exp=0101", bus4.y_q);
        end
        checks++;
        if (bus4.y_rise !== 4'b0101) begin
            failures++; $display("FAIL wide_y_rise got=%b exp=0101", bus4.y_rise);
        end
        @(negedge clk);
        bus4.a = 4'b0010; bus4.b = 4'b0000;
        @(posedge clk);
        #1;
        checks++;
        if (bus4.y_rise !== 4'b0010) begin
            failures++; $display("FAIL wide_y_rise_lane1 got=%b exp=0010", bus4.y_rise);
        end
        checks++;
        if (bus4.hi_cnt !== 16'd2) begin
            failures++; $display("FAIL wide_hi_cnt got=%0d exp=2", bus4.hi_cnt);
        end
    endtask

    task automatic test_reset_mid_count();
        @(negedge clk);
        bus1.a = 1'b1; bus1.b = 1'b0; bus1.c = 1'b0; bus1.clr = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus1.hi_cnt !== 16'd0) begin
            failures++; $display("FAIL rst_mid_hi_cnt got=%0d exp=0", bus1.hi_cnt);
        end
        checks++;
        if (bus1.y_q !== 1'b0) begin
            failures++; $display("FAIL rst_mid_y_q got=%b exp=0", bus1.y_q);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus1.y_rise !== 1'b1) begin
            failures++; $display("FAIL rst_release_y_rise got=%b exp=1", bus1.y_rise);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        bus1.a = 1'b0; bus1.b = 1'b0; bus1.c = 1'b0; bus1.clr = 1'b0;
        bus_sat.a = 1'b0; bus_sat.b = 1'b0; bus_sat.c = 1'b0; bus_sat.clr = 1'b0;
        bus4.a = 4'h0; bus4.b = 4'h0; bus4.c = 4'h0; bus4.clr = 1'b0;

        test_truth_table();
        test_reset();
        test_hold_high();
        test_toggle();
        test_saturate_clear();
        test_wide();
        test_reset_mid_count();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
